// File: rtl/alu_wb_stage_pkg.sv
// alu_wb_stage_pkg: shared widths and flag bit positions for the ALU writeback stage
package alu_wb_stage_pkg;
  localparam int DATA_W = 8;
  localparam int RD_W = 6;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;
endpackage

// File: rtl/alu_wb_stage_if.sv
// alu_wb_stage_if: execute-side and writeback-side signals of the ALU writeback stage
interface alu_wb_stage_if #(
  parameter int DATA_W = alu_wb_stage_pkg::DATA_W,
  parameter int RD_W = alu_wb_stage_pkg::RD_W,
  parameter int DEPTH = 2
);
  logic in_valid, in_ready;
  logic [DATA_W-1:0] alu_out, in_target;
  logic alu_z, alu_n, in_we, in_setf, in_brz, in_brn;
  logic [RD_W-1:0] in_rd, wb_rd;
  logic wb_valid, wb_ready;
  logic [DATA_W-1:0] wb_data, br_pc;
  logic flag_z, flag_n, br_taken;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, alu_out, alu_z, alu_n, in_rd, in_we, in_setf, in_brz, in_brn, in_target, wb_ready,
    input in_ready, wb_valid, wb_data, wb_rd, flag_z, flag_n, br_taken, br_pc, count
  );
  modport slave (
    input in_valid, alu_out, alu_z, alu_n, in_rd, in_we, in_setf, in_brz, in_brn, in_target, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd, flag_z, flag_n, br_taken, br_pc, count
  );
endinterface

// File: rtl/alu_wb_stage_fifo.sv
// wb_fifo: synchronous FIFO with registered storage and power-of-two wrapping pointers
module wb_fifo #(
  parameter int W = 14,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (rst_n) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: buffers ALU results toward the register file, keeps Z/N flags
// and resolves BRZ/BRN branches into a one-cycle taken pulse.
module alu_wb_stage import alu_wb_stage_pkg::*; #(
  parameter int DATA_W = alu_wb_stage_pkg::DATA_W,
  parameter int RD_W = alu_wb_stage_pkg::RD_W,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  alu_wb_stage_if.slave bus
);
  logic acc, take, full, empty;
  logic [1:0] flags;
  logic [DATA_W+RD_W-1:0] head;
  assign bus.in_ready = !full;
  assign acc = bus.in_valid & bus.in_ready;
  // branches see the flags committed before this edge, even when the same op sets them
  assign take = (bus.in_brz & flags[FLAG_Z]) | (bus.in_brn & flags[FLAG_N]);
  assign bus.wb_valid = !empty;
  assign {bus.wb_data, bus.wb_rd} = head;
  assign bus.flag_z = flags[FLAG_Z];
  assign bus.flag_n = flags[FLAG_N];
  wb_fifo #(.W(DATA_W + RD_W), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(acc & bus.in_we),
    .pop(bus.wb_valid & bus.wb_ready),
    .din({bus.alu_out, bus.in_rd}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(bus.count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flags <= '0;
      bus.br_taken <= 1'b0;
      bus.br_pc <= '0;
    end else begin
      bus.br_taken <= acc & take;
      if (acc & take) bus.br_pc <= bus.in_target;
      if (acc & bus.in_setf) begin
        flags[FLAG_Z] <= bus.alu_z;
        flags[FLAG_N] <= bus.alu_n;
      end
    end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed and randomized checks of alu_wb_stage against a queue-based model
module tb_alu_wb_stage;
  import alu_wb_stage_pkg::*;
  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = DATA_W + RD_W;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  alu_wb_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) bus();
  alu_wb_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0, fails = 0;
  logic [EW-1:0] q[$];
  logic mz = 0, mn = 0, mbr = 0;
  logic [DATA_W-1:0] mpc = '0;

  task automatic idle();
    bus.in_valid = 0; bus.alu_out = '0; bus.in_rd = '0; bus.in_we = 0; bus.in_setf = 0;
    bus.alu_z = 0; bus.alu_n = 0; bus.in_brz = 0; bus.in_brn = 0; bus.in_target = '0;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd, input logic we, setf, z, n, brz, brn,
                       input logic [DATA_W-1:0] tgt);
    bus.in_valid = 1; bus.alu_out = d; bus.in_rd = rd; bus.in_we = we; bus.in_setf = setf;
    bus.alu_z = z; bus.alu_n = n; bus.in_brz = brz; bus.in_brn = brn; bus.in_target = tgt;
  endtask

  task automatic model_reset();
    q.delete(); mz = 0; mn = 0; mbr = 0; mpc = '0;
  endtask

  // advance one clock and apply the reference rules to the inputs seen at that edge
  task automatic step();
    logic acc, pop, tk, we, setf, z, n;
    logic [EW-1:0] e;
    logic [DATA_W-1:0] tgt;
    acc = bus.in_valid && q.size() < DEPTH;
    pop = q.size() > 0 && bus.wb_ready;
    tk = acc && ((bus.in_brz && mz) || (bus.in_brn && mn));
    we = bus.in_we; setf = bus.in_setf; z = bus.alu_z; n = bus.alu_n; tgt = bus.in_target;
    e = {bus.alu_out, bus.in_rd};
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc && we) q.push_back(e);
    mbr = tk;
    if (tk) mpc = tgt;
    if (acc && setf) begin mz = z; mn = n; end
  endtask

  task automatic test_reset();
    tests++; if (bus.count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    tests++; if ({bus.flag_z, bus.flag_n, bus.br_taken} !== 3'b000) begin fails++; $display("FAIL reset_flags_br got %b exp 000", {bus.flag_z, bus.flag_n, bus.br_taken}); end
    tests++; if ({bus.wb_data, bus.wb_rd, bus.br_pc} !== '0) begin fails++; $display("FAIL reset_data got %h/%h/%h exp 0", bus.wb_data, bus.wb_rd, bus.br_pc); end
    @(negedge clk); rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 0;
    drive(8'hAA, 1, 1, 1, 1, 0, 0, 0, 0); step();
    drive(8'hBB, 2, 1, 0, 0, 0, 1, 0, 8'h77); step();
    tests++; if (bus.count !== CW'(2)) begin fails++; $display("FAIL mid_pre_count got %0d exp 2", bus.count); end
    tests++; if (bus.br_taken !== 1'b1) begin fails++; $display("FAIL mid_pre_br got %b exp 1", bus.br_taken); end
    #2 rst_n = 0;
    #1;
    tests++; if (bus.count !== '0 || bus.wb_valid !== 1'b0) begin fails++; $display("FAIL mid_async_fifo got count=%0d valid=%b exp 0/0", bus.count, bus.wb_valid); end
    tests++; if ({bus.flag_z, bus.flag_n, bus.br_taken} !== 3'b000 || bus.br_pc !== '0) begin fails++; $display("FAIL mid_async_flags got zn_br=%b pc=%h exp 000/00", {bus.flag_z, bus.flag_n, bus.br_taken}, bus.br_pc); end
    model_reset();
    idle();
    @(negedge clk); rst_n = 1;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL mid_release_ready got %b exp 1", bus.in_ready); end
    bus.wb_ready = 1;
    drive(8'h5C, 4, 1, 0, 0, 0, 0, 0, 0); step();
    tests++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h5C) begin fails++; $display("FAIL mid_first_accept got valid=%b data=%h exp 1/5c", bus.wb_valid, bus.wb_data); end
    idle(); step();
  endtask

  task automatic test_single_write();
    bus.wb_ready = 1;
    drive(8'h5A, 3, 1, 0, 0, 0, 0, 0, 0); step();
    idle();
    tests++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 8'h5A || bus.wb_rd !== 6'd3) begin fails++; $display("FAIL single_head got valid=%b data=%h rd=%0d exp 1/5a/3", bus.wb_valid, bus.wb_data, bus.wb_rd); end
    step();
    tests++; if (bus.wb_valid !== 1'b0) begin fails++; $display("FAIL single_drain got valid=%b exp 0", bus.wb_valid); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] got[$];
    logic acc_now;
    bus.wb_ready = 0;
    drive(8'h11, 1, 1, 0, 0, 0, 0, 0, 0); step();
    drive(8'h22, 2, 1, 0, 0, 0, 0, 0, 0); step();
    tests++; if (bus.count !== CW'(2) || bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got count=%0d ready=%b exp 2/0", bus.count, bus.in_ready); end
    drive(8'h99, 5, 1, 0, 0, 0, 0, 0, 0); step();
    tests++; if (bus.count !== CW'(2) || bus.wb_data !== 8'h11) begin fails++; $display("FAIL bp_third_offer got count=%0d head=%h exp 2/11", bus.count, bus.wb_data); end
    bus.wb_ready = 1;
    drive(8'h33, 3, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && got.size() < 4; i++) begin
      if (bus.wb_valid) got.push_back(bus.wb_data);
      acc_now = bus.in_valid && bus.in_ready;
      step();
      if (acc_now) idle();
    end
    tests++; if (got.size() != 3 || got[0] !== 8'h11 || got[1] !== 8'h22 || got[2] !== 8'h33) begin fails++; $display("FAIL bp_order got n=%0d %p exp 11,22,33", got.size(), got); end
    tests++; if (bus.count !== '0 || bus.wb_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got count=%0d valid=%b exp 0/0", bus.count, bus.wb_valid); end
  endtask

  task automatic test_flags();
    bus.wb_ready = 1;
    drive(8'h00, 7, 1, 1, 1, 0, 0, 0, 0); step();
    tests++; if ({bus.flag_z, bus.flag_n} !== 2'b10) begin fails++; $display("FAIL flags_zero got zn=%b exp 10", {bus.flag_z, bus.flag_n}); end
    drive(8'h80, 7, 1, 1, 0, 1, 0, 0, 0); step();
    tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin fails++; $display("FAIL flags_neg got zn=%b exp 01", {bus.flag_z, bus.flag_n}); end
    drive(8'h00, 7, 1, 0, 1, 0, 0, 0, 0); step();
    tests++; if ({bus.flag_z, bus.flag_n} !== 2'b01) begin fails++; $display("FAIL flags_hold got zn=%b exp 01", {bus.flag_z, bus.flag_n}); end
    idle(); step();
  endtask

  task automatic test_branch();
    bus.wb_ready = 1;
    drive(8'h00, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h40); step();
    tests++; if (bus.br_taken !== 1'b1 || bus.br_pc !== 8'h40) begin fails++; $display("FAIL br_brz_taken got br=%b pc=%h exp 1/40", bus.br_taken, bus.br_pc); end
    idle(); step();
    tests++; if (bus.br_taken !== 1'b0 || bus.br_pc !== 8'h40) begin fails++; $display("FAIL br_pulse_end got br=%b pc=%h exp 0/40", bus.br_taken, bus.br_pc); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h20); step();
    tests++; if (bus.br_taken !== 1'b0 || bus.br_pc !== 8'h40) begin fails++; $display("FAIL br_brn_not_taken got br=%b pc=%h exp 0/40", bus.br_taken, bus.br_pc); end
    drive(8'h00, 0, 0, 1, 0, 1, 0, 1, 8'h30); step();
    tests++; if (bus.br_taken !== 1'b0 || {bus.flag_z, bus.flag_n} !== 2'b01) begin fails++; $display("FAIL br_old_flags got br=%b zn=%b exp 0/01", bus.br_taken, {bus.flag_z, bus.flag_n}); end
    drive(8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h50); step();
    tests++; if (bus.br_taken !== 1'b1 || bus.br_pc !== 8'h50) begin fails++; $display("FAIL br_both got br=%b pc=%h exp 1/50", bus.br_taken, bus.br_pc); end
    idle(); step();
    tests++; if (bus.br_taken !== 1'b0 || bus.br_pc !== 8'h50 || {bus.flag_z, bus.flag_n} !== 2'b01) begin fails++; $display("FAIL br_idle_hold got br=%b pc=%h zn=%b exp 0/50/01", bus.br_taken, bus.br_pc, {bus.flag_z, bus.flag_n}); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0] rd;
    bus.wb_ready = 1;
    drive(8'hC3, 9, 1, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 12; i++) begin
      d = DATA_W'($urandom); rd = RD_W'($urandom);
      drive(d, rd, 1, 0, 0, 0, 0, 0, 0); step();
      tests++; if (bus.count !== CW'(1) || {bus.wb_data, bus.wb_rd} !== {d, rd}) begin fails++; $display("FAIL b2b_%0d got count=%0d head=%h/%0d exp 1/%h/%0d", i, bus.count, bus.wb_data, bus.wb_rd, d, rd); end
    end
    idle(); step();
  endtask

  task automatic test_random();
    logic [CW-1:0] ec;
    for (int i = 0; i < 400; i++) begin
      bus.wb_ready = $urandom_range(0, 99) < 60;
      if ($urandom_range(0, 99) < 70)
        drive(DATA_W'($urandom), RD_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, DATA_W'($urandom));
      else idle();
      step();
      ec = CW'(q.size());
      tests++; if (bus.count !== ec) begin fails++; $display("FAIL rnd_count@%0d got %0d exp %0d", i, bus.count, ec); end
      tests++; if (bus.wb_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < DEPTH)) begin fails++; $display("FAIL rnd_hs@%0d got valid=%b ready=%b exp n=%0d", i, bus.wb_valid, bus.in_ready, q.size()); end
      if (q.size() > 0) begin
        tests++; if ({bus.wb_data, bus.wb_rd} !== q[0]) begin fails++; $display("FAIL rnd_head@%0d got %h exp %h", i, {bus.wb_data, bus.wb_rd}, q[0]); end
      end
      tests++; if ({bus.flag_z, bus.flag_n} !== {mz, mn}) begin fails++; $display("FAIL rnd_flags@%0d got %b exp %b", i, {bus.flag_z, bus.flag_n}, {mz, mn}); end
      tests++; if (bus.br_taken !== mbr || bus.br_pc !== mpc) begin fails++; $display("FAIL rnd_br@%0d got %b/%h exp %b/%h", i, bus.br_taken, bus.br_pc, mbr, mpc); end
    end
    idle();
  endtask

  initial begin
    idle();
    bus.wb_ready = 0;
    #12;
    test_reset();
    test_single_write();
    test_backpressure();
    test_flags();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_wb_stage.md
Name: alu_wb_stage

Overview:
- Registered execute-to-writeback stage directly downstream of the 8-bit ALU.
- Captures the ALU result and its Z/N outputs with the destination tag, and buffers them in a small FIFO toward the register-file write port using a valid/ready handshake.
- Keeps the architectural Z/N flag register.
- Resolves conditional branches (BRZ/BRN) against the committed flags and emits a one-cycle taken pulse with its target.

Parameters:
- DATA_W, 8: ALU result width.
- RD_W, 6: destination register index width.
- DEPTH, 2: result FIFO entries; a power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has an executed instruction
- in_ready  output  1  stage can accept this cycle
- alu_out  input  DATA_W  ALU Out
- alu_z  input  1  ALU Z
- alu_n  input  1  ALU N
- in_rd  input  RD_W  destination register index
- in_we  input  1  instruction writes a register
- in_setf  input  1  instruction updates Z/N flags
- in_brz  input  1  branch if flag Z
- in_brn  input  1  branch if flag N
- in_target  input  DATA_W  branch target PC
- wb_valid  output  1  FIFO head is valid
- wb_ready  input  1  register file accepts the head
- wb_data  output  DATA_W  head result
- wb_rd  output  RD_W  head destination
- flag_z  output  1  committed Z flag
- flag_n  output  1  committed N flag
- br_taken  output  1  one-cycle pulse, branch taken
- br_pc  output  DATA_W  target, valid while br_taken=1
- count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FIFO empty, so count=0, wb_valid=0 and in_ready=1. wb_data, wb_rd, br_pc, flag_z, flag_n and br_taken are all 0.
- Reset mid-operation drops every buffered entry and any pending br_taken with no partial writeback. The first accept is possible on the first rising edge after deassertion.
- Accept condition: acc = in_valid & in_ready, with in_ready = (count < DEPTH). in_ready is combinational from count only, never from in_valid.
- FIFO enqueue: an accepted instruction with in_we=1 enqueues {alu_out, in_rd}. Instructions with in_we=0 are consumed without enqueueing.
- FIFO dequeue: the head is removed when wb_valid & wb_ready. wb_data and wb_rd are registered storage, never combinational from alu_out.
- Latency: accept at edge N gives wb_valid=1 after edge N when the FIFO was empty, i.e. one cycle.
- Simultaneous enqueue and dequeue: count is unchanged. This is legal when full because in_ready depends only on count, so no accept occurs at DEPTH.
- Pointers: rd/wr pointers wrap modulo DEPTH. count saturates at neither end; overflow and underflow are impossible by construction and are asserted in simulation.
- Flag update: on acc with in_setf=1, flag_z<=alu_z and flag_n<=alu_n at that edge. Flags update at accept, not at dequeue, because acceptance is in program order.
- Branch resolution:
  - On acc with in_brz=1, take = flag_z; with in_brn=1, take = flag_n. The flag value used is the one before the edge.
  - If taken, br_taken=1 for exactly the next cycle and br_pc=in_target (registered).
  - in_brz and in_brn both 1 means take = flag_z | flag_n.
  - A branch with in_setf=1 resolves on the old flags, then updates them.
- Not-taken branch or non-branch: br_taken=0 next cycle. br_pc holds its last value.
- in_valid=0 or in_ready=0: nothing is latched; flags and branch outputs are unchanged except that br_taken falls to 0.
- No internal FSM beyond FIFO occupancy. br_taken is a single flop.

Decomposition:
- Shared package (constants header): DATA_W, RD_W, flag bit positions Z=1 and N=0.
- Natural sub-module: wb_fifo, a synchronous FIFO with parameters DATA_W+RD_W and DEPTH, ports push/pop/full/empty/count and an async active-low reset.
- Flag register and branch logic stay in alu_wb_stage.

Test Plan:
- Reset then idle: rst_n=0 mid-run with 2 entries buffered -> count=0, wb_valid=0, flags=0, br_taken=0 immediately (asynchronous); in_ready=1 after release.
- Single write: accept alu_out=0x5A, rd=3, we=1 with wb_ready=1 -> next cycle wb_valid=1, wb_data=0x5A, wb_rd=3; following cycle wb_valid=0.
- Backpressure/full: wb_ready=0, push 0x11, 0x22 -> count=2, in_ready=0, third offer not accepted. Then wb_ready=1 with in_valid held on 0x33 -> dequeue order 0x11, 0x22, 0x33 with no loss or duplication.
- Flags: accept setf with alu_out=0x00, Z=1 -> flag_z=1, flag_n=0. Then setf with 0x80, N=1 -> flag_z=0, flag_n=1. An instruction with setf=0 leaves the flags unchanged.
- Branch: flag_z=1, accept brz target 0x40 -> br_taken=1 for one cycle, br_pc=0x40. flag_n=0, accept brn target 0x20 -> br_taken stays 0.
- Simultaneous push and pop at count=1 -> count stays 1, and data order is preserved across pointer wrap-around over 10 or more transactions.
